// File: rtl/hybrid_branch_predictor_if.sv
// Fetch-side lookup and EX-side resolve channels of the hybrid branch predictor.
// The master drives fetch PCs and resolved branches; the predictor is the slave.
interface hybrid_branch_predictor_if #(
  parameter int XLEN     = 32,
  parameter int GHR_BITS = 6
);
  logic                lookup_valid;
  logic [XLEN-1:0]     lookup_pc;
  logic                pred_hit;
  logic                pred_taken;
  logic [XLEN-1:0]     pred_target;
  logic [GHR_BITS-1:0] pred_ghr;

  logic                upd_valid;
  logic                upd_cond;
  logic [XLEN-1:0]     upd_pc;
  logic [GHR_BITS-1:0] upd_ghr;
  logic                upd_taken;
  logic [XLEN-1:0]     upd_target;

  modport master (
    output lookup_valid, lookup_pc,
    output upd_valid, upd_cond, upd_pc, upd_ghr, upd_taken, upd_target,
    input  pred_hit, pred_taken, pred_target, pred_ghr
  );

  modport slave (
    input  lookup_valid, lookup_pc,
    input  upd_valid, upd_cond, upd_pc, upd_ghr, upd_taken, upd_target,
    output pred_hit, pred_taken, pred_target, pred_ghr
  );
endinterface

// File: rtl/hybrid_branch_predictor.sv
// Tournament predictor: bimodal + gshare PHTs with a per-PC chooser, plus a
// direct-mapped BTB. Lookup is combinational; training happens at resolve.
module hybrid_branch_predictor #(
  parameter int XLEN     = 32,
  parameter int PHT_LOG2 = 6,
  parameter int GHR_BITS = 6,
  parameter int BTB_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  hybrid_branch_predictor_if.slave bp
);
  localparam int PHT_N = 1 << PHT_LOG2;
  localparam int BTB_N = 1 << BTB_LOG2;
  localparam int TAG_W = XLEN - BTB_LOG2 - 2;

  typedef logic [1:0] ctr_t;

  ctr_t [PHT_N-1:0]                loc_q, gsh_q, cho_q;
  logic [BTB_N-1:0]                btb_vld_q;
  logic [BTB_N-1:0][TAG_W-1:0]     btb_tag_q;
  logic [BTB_N-1:0][XLEN-1:0]      btb_tgt_q;
  logic [GHR_BITS-1:0]             ghr_q, ghr_d;

  function automatic ctr_t ctr_step(ctr_t c, logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Lookup path
  logic [PHT_LOG2-1:0] l_lidx, l_gidx;
  logic [BTB_LOG2-1:0] l_bidx;
  logic [TAG_W-1:0]    l_tag;
  logic                l_dir;

  assign l_lidx = bp.lookup_pc[PHT_LOG2+1:2];
  assign l_gidx = l_lidx ^ PHT_LOG2'(ghr_q);
  assign l_bidx = bp.lookup_pc[BTB_LOG2+1:2];
  assign l_tag  = bp.lookup_pc[XLEN-1:BTB_LOG2+2];
  assign l_dir  = cho_q[l_lidx][1] ? gsh_q[l_gidx][1] : loc_q[l_lidx][1];

  assign bp.pred_hit    = bp.lookup_valid & ~rst & btb_vld_q[l_bidx] &
                          (btb_tag_q[l_bidx] == l_tag);
  assign bp.pred_taken  = bp.pred_hit & l_dir;
  assign bp.pred_target = bp.pred_taken ? btb_tgt_q[l_bidx] : bp.lookup_pc + XLEN'(4);
  assign bp.pred_ghr    = ghr_q;

  // Update path: gshare is indexed with the history seen at lookup time
  logic [PHT_LOG2-1:0] u_lidx, u_gidx;
  logic [BTB_LOG2-1:0] u_bidx;
  logic [TAG_W-1:0]    u_tag;
  logic                u_lmsb, u_gmsb;
  logic                unused_upd_pc_lsb;

  assign u_lidx = bp.upd_pc[PHT_LOG2+1:2];
  assign u_gidx = u_lidx ^ PHT_LOG2'(bp.upd_ghr);
  assign u_bidx = bp.upd_pc[BTB_LOG2+1:2];
  assign u_tag  = bp.upd_pc[XLEN-1:BTB_LOG2+2];
  assign u_lmsb = loc_q[u_lidx][1];
  assign u_gmsb = gsh_q[u_gidx][1];
  assign ghr_d  = GHR_BITS'({ghr_q, bp.upd_taken});
  assign unused_upd_pc_lsb = ^bp.upd_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      loc_q     <= {PHT_N{2'b01}};
      gsh_q     <= {PHT_N{2'b01}};
      cho_q     <= {PHT_N{2'b01}};
      btb_vld_q <= '0;
      btb_tag_q <= '0;
      btb_tgt_q <= '0;
      ghr_q     <= '0;
    end else if (bp.upd_valid) begin
      if (bp.upd_cond) begin
        loc_q[u_lidx] <= ctr_step(loc_q[u_lidx], bp.upd_taken);
        gsh_q[u_gidx] <= ctr_step(gsh_q[u_gidx], bp.upd_taken);
        // Chooser only learns when the two components disagreed
        if (u_lmsb != u_gmsb)
          cho_q[u_lidx] <= ctr_step(cho_q[u_lidx], u_gmsb == bp.upd_taken);
        ghr_q <= ghr_d;
      end
      if (bp.upd_taken) begin
        btb_vld_q[u_bidx] <= 1'b1;
        btb_tag_q[u_bidx] <= u_tag;
        btb_tgt_q[u_bidx] <= bp.upd_target;
      end
    end
  end
endmodule

// File: tb/tb_hybrid_branch_predictor.sv
// Directed bench for hybrid_branch_predictor: a table-level model is checked
// against the DUT every cycle, and literal expectations pin the model.
module tb_hybrid_branch_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hybrid_branch_predictor_if #(.XLEN(32), .GHR_BITS(6)) bp ();

  hybrid_branch_predictor #(.XLEN(32), .PHT_LOG2(6), .GHR_BITS(6), .BTB_LOG2(4)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  int tests = 0;
  int fails = 0;

  // Model state: plain integer counters and BTB fields
  int          lc [64];
  int          gc [64];
  int          cc [64];
  bit          bv [16];
  int unsigned btag [16];
  int unsigned btgt [16];
  int          ghr_m = 0;
  bit          armed = 1'b0;

  function automatic int sat(int v);
    return (v < 0) ? 0 : (v > 3) ? 3 : v;
  endfunction

  always @(posedge clk) begin : model
    int li, gi, bi;
    bit lm, gm, tk;
    if (rst) begin
      for (int i = 0; i < 64; i++) begin lc[i] = 1; gc[i] = 1; cc[i] = 1; end
      for (int i = 0; i < 16; i++) begin bv[i] = 0; btag[i] = 0; btgt[i] = 0; end
      ghr_m = 0;
      armed = 1'b1;
    end else if (bp.upd_valid) begin
      li = int'((bp.upd_pc / 4) % 64);
      gi = li ^ int'(bp.upd_ghr);
      bi = int'((bp.upd_pc / 4) % 16);
      tk = bp.upd_taken;
      if (bp.upd_cond) begin
        lm = (lc[li] >= 2);
        gm = (gc[gi] >= 2);
        lc[li] = sat(lc[li] + (tk ? 1 : -1));
        gc[gi] = sat(gc[gi] + (tk ? 1 : -1));
        if (lm != gm) cc[li] = sat(cc[li] + ((gm == tk) ? 1 : -1));
        ghr_m = (ghr_m * 2 + int'(tk)) % 64;
      end
      if (tk) begin
        bv[bi]   = 1;
        btag[bi] = bp.upd_pc / 64;
        btgt[bi] = bp.upd_target;
      end
    end
  end

  always @(negedge clk) begin : compare
    int li, gi, bi;
    bit e_hit, e_tk, dir;
    logic [31:0] e_tgt;
    if (armed) begin
      li = int'((bp.lookup_pc / 4) % 64);
      gi = li ^ ghr_m;
      bi = int'((bp.lookup_pc / 4) % 16);
      e_hit = !rst && bp.lookup_valid && bv[bi] && (btag[bi] == bp.lookup_pc / 64);
      dir   = (cc[li] >= 2) ? (gc[gi] >= 2) : (lc[li] >= 2);
      e_tk  = e_hit && dir;
      e_tgt = e_tk ? btgt[bi] : bp.lookup_pc + 32'd4;
      tests++;
      if (bp.pred_hit !== e_hit || bp.pred_taken !== e_tk ||
          bp.pred_target !== e_tgt || bp.pred_ghr !== 6'(ghr_m)) begin
        fails++;
        $display("FAIL model_cmp t=%0t pc=%h got hit=%b tk=%b tgt=%h ghr=%h exp hit=%b tk=%b tgt=%h ghr=%h",
                 $time, bp.lookup_pc, bp.pred_hit, bp.pred_taken, bp.pred_target, bp.pred_ghr,
                 e_hit, e_tk, e_tgt, 6'(ghr_m));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Present a lookup, check it mid-cycle, then advance one clock
  task automatic look(input string name, input logic [31:0] pc, input logic ehit,
                      input logic etk, input logic [31:0] etgt, input logic [5:0] eghr);
    bp.lookup_valid = 1'b1;
    bp.lookup_pc    = pc;
    @(negedge clk);
    chk({name, "_hit"},    32'(bp.pred_hit),   32'(ehit));
    chk({name, "_taken"},  32'(bp.pred_taken), 32'(etk));
    chk({name, "_target"}, bp.pred_target,     etgt);
    chk({name, "_ghr"},    32'(bp.pred_ghr),   32'(eghr));
    @(posedge clk); #1;
    bp.lookup_valid = 1'b0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic cond, input logic tk,
                         input logic [31:0] tgt, input logic [5:0] ghr);
    bp.upd_valid  = 1'b1;
    bp.upd_cond   = cond;
    bp.upd_pc     = pc;
    bp.upd_taken  = tk;
    bp.upd_target = tgt;
    bp.upd_ghr    = ghr;
  endtask

  task automatic upd(input logic [31:0] pc, input logic cond, input logic tk,
                     input logic [31:0] tgt, input logic [5:0] ghr);
    set_upd(pc, cond, tk, tgt, ghr);
    @(posedge clk); #1;
    bp.upd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bp.lookup_valid = 1'b0; bp.lookup_pc = '0;
    bp.upd_valid = 1'b0; bp.upd_cond = 1'b0; bp.upd_pc = '0;
    bp.upd_ghr = '0; bp.upd_taken = 1'b0; bp.upd_target = '0;

    // Reset state
    do_reset();
    look("t1_reset", 32'h100, 0, 0, 32'h104, 6'd0);

    // First taken training installs BTB entry and shifts GHR
    upd(32'h100, 1, 1, 32'h80, 6'd0);
    look("t2_trained", 32'h100, 1, 1, 32'h80, 6'd1);

    // Saturation then two not-taken steps
    repeat (5) upd(32'h100, 1, 1, 32'h80, 6'd0);
    upd(32'h100, 1, 0, 32'h80, 6'd0);
    look("t3_sat_nt1", 32'h100, 1, 1, 32'h80, 6'd62);
    upd(32'h100, 1, 0, 32'h80, 6'd0);
    look("t3_sat_nt2", 32'h100, 1, 0, 32'h104, 6'd60);

    // BTB alias at index 0
    do_reset();
    upd(32'h100, 1, 1, 32'h80, 6'd0);
    upd(32'h140, 1, 1, 32'h300, 6'd0);
    look("t4_alias_old", 32'h100, 0, 0, 32'h104, 6'd3);
    look("t4_alias_new", 32'h140, 1, 1, 32'h300, 6'd3);

    // Chooser trained toward gshare; local alone would predict taken here
    do_reset();
    upd(32'h200, 1, 1, 32'h400, 6'd0);
    upd(32'h200, 1, 0, 32'h400, 6'd1);
    upd(32'h200, 1, 1, 32'h400, 6'd0);
    look("t5_gshare", 32'h200, 1, 0, 32'h204, 6'd5);
    upd(32'h200, 0, 1, 32'h500, 6'd5);
    look("t5_jump", 32'h200, 1, 0, 32'h204, 6'd5);

    // Same-cycle lookup and update sees the old state
    do_reset();
    upd(32'h100, 1, 1, 32'h80, 6'd0);
    set_upd(32'h100, 1, 0, 32'h80, 6'd0);
    look("t6_old", 32'h100, 1, 1, 32'h80, 6'd1);
    bp.upd_valid = 1'b0;
    look("t6_new", 32'h100, 1, 0, 32'h104, 6'd2);

    // Reset wins over a concurrent update
    rst = 1'b1;
    set_upd(32'h100, 1, 1, 32'h80, 6'd0);
    look("t6_in_rst", 32'h100, 0, 0, 32'h104, 6'd2);
    rst = 1'b0;
    bp.upd_valid = 1'b0;
    look("t6_after_rst", 32'h100, 0, 0, 32'h104, 6'd0);

    // Lookup not valid on a trained PC
    upd(32'h100, 1, 1, 32'h80, 6'd0);
    @(negedge clk);
    chk("t7_novalid_hit", 32'(bp.pred_hit), 32'd0);
    chk("t7_novalid_target", bp.pred_target, 32'h104);
    look("t7_valid", 32'h100, 1, 1, 32'h80, 6'd1);

    // PC+4 wraps at the top of the address space
    look("t8_wrap", 32'hFFFF_FFFC, 0, 0, 32'h0, 6'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
